// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register index type, pipeline controller
// state encoding and pipeline latch indices.
package cpu_types_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    HALT   = 2'd2
  } pipectrl_state_t;

  localparam int N_LAT     = 4;
  localparam int LAT_IFID  = 0;
  localparam int LAT_IDEX  = 1;
  localparam int LAT_EXMEM = 2;
  localparam int LAT_MEMWB = 3;

endpackage

// File: rtl/pipectrl_perf.sv
// Stall and flush performance counters. Both are free-running 32-bit
// counters that wrap, each advanced by a single-cycle strobe.
module pipectrl_perf (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Next-count: add one when the strobe is high, wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_inc};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_inc};
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal operation, hazards resolved cycle by cycle
// DSTALL | data access outstanding; whole pipe frozen until dhit
// HALT   | halt retired; latches disabled, only nRST leaves
//
// All controls are combinational from state, squash_pending and inputs.
// squash_pending remembers that a redirect happened while a fetch was
// outstanding, so the instruction that eventually returns is wrong-path.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             ex_memread,
  input  regbits_t         ex_rd,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             ex_br_taken,
  input  logic             id_jump,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic [N_LAT-1:0] lat_en,
  output logic [N_LAT-1:0] lat_freeze,
  output logic [N_LAT-1:0] lat_flush,
  output logic             halt_o,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
);

  pipectrl_state_t  state_q, state_d;
  logic             squash_pending_q, squash_pending_d;

  logic             halt_hit;
  logic             dmem_stall;
  logic             load_use;
  logic             squash_hit;
  logic [N_LAT-1:0] freeze_raw;
  logic [N_LAT-1:0] flush_raw;
  logic             stall_inc;
  logic             flush_inc;

  // Hazard detection terms.
  always_comb begin
    halt_hit   = (state_q == HALT) | wb_halt;
    dmem_stall = (mem_dren | mem_dwen) & ~dhit;
    load_use   = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    squash_hit = squash_pending_q & ihit;
  end

  // Prioritised control decode and next-state.
  always_comb begin
    state_d          = RUN;
    squash_pending_d = squash_pending_q;
    pc_en            = 1'b1;
    freeze_raw       = '0;
    flush_raw        = '0;
    flush_inc        = 1'b0;

    if (halt_hit) begin
      state_d = HALT;
      pc_en   = 1'b0;
    end else if (dmem_stall) begin
      // A taken branch in EX stays frozen and is acted on after release.
      state_d    = DSTALL;
      pc_en      = 1'b0;
      freeze_raw = '1;
    end else if (ex_br_taken) begin
      flush_raw[LAT_IFID] = 1'b1;
      flush_raw[LAT_IDEX] = 1'b1;
      flush_inc           = 1'b1;
      squash_pending_d    = ~ihit;
    end else if (load_use) begin
      pc_en                = 1'b0;
      freeze_raw[LAT_IFID] = 1'b1;
      flush_raw[LAT_IDEX]  = 1'b1;
    end else if (id_jump) begin
      flush_raw[LAT_IFID] = 1'b1;
      flush_inc           = 1'b1;
      squash_pending_d    = ~ihit;
    end else if (squash_hit) begin
      pc_en               = 1'b0;
      flush_raw[LAT_IFID] = 1'b1;
      squash_pending_d    = 1'b0;
    end else if (!ihit) begin
      pc_en               = 1'b0;
      flush_raw[LAT_IFID] = 1'b1;
    end
  end

  // Latch controls; a frozen latch never sees a flush.
  always_comb begin
    lat_en     = (state_q == HALT) ? '0 : '1;
    lat_freeze = freeze_raw;
    lat_flush  = flush_raw & ~freeze_raw;
    halt_o     = halt_hit;
    stall_inc  = ~pc_en & (state_q != HALT);
  end

  // State and squash-pending registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q          <= RUN;
      squash_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      squash_pending_q <= squash_pending_d;
    end
  end

  pipectrl_perf u_perf (
    .CLK       (CLK),
    .nRST      (nRST),
    .stall_inc (stall_inc),
    .flush_inc (flush_inc),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

endmodule
